lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
//  Sequences LM/SM (load/store multiple) in the 6-stage pipeline. Takes one decoded LM/SM, its 8-bit
//  register mask and base address, and issues one register micro-op per set mask bit to the memory stage.
//  Issue order is R0 first (mask[7]) down to R7 (mask[0]). Holds fetch/decode stalled until the last
//  micro-op is accepted. Sits between decode (register read) and the memory stage.
// PARAMETERS
//  ADDR_W   16  memory address / register data width
//  MASK_W   8   register-mask width; one bit per architectural register
//  REG_W    3   register index width, log2(MASK_W)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       decode presents a valid instruction this cycle
//  opcode      in   4       decoded opcode; 4'b1100 = LM, 4'b1101 = SM
//  imm_mask    in   MASK_W  register mask from instruction bits [7:0]
//  base_addr   in   ADDR_W  RF read data of base register
//  flush       in   1       pipeline flush; aborts the sequence
//  uop_ready   in   1       memory stage accepts the current micro-op
//  uop_valid   out  1       micro-op present
//  uop_is_load out  1       1 = LM (mem->reg), 0 = SM (reg->mem)
//  uop_reg     out  REG_W   register index of the current micro-op
//  uop_addr    out  ADDR_W  memory address of the current micro-op
//  uop_last    out  1       current micro-op is the final one of the instruction
//  stall       out  1       hold PC and the decode latch
//  done        out  1       one-cycle pulse: instruction fully retired by the sequencer
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE, mask_q=0, addr_q=0, is_load_q=0. All outputs 0.
//  - FSM states: IDLE, ISSUE.
//  - IDLE and start and opcode in {LM,SM}:
//      imm_mask!=0: latch mask_q=imm_mask, addr_q=base_addr, is_load_q=(opcode==LM). Next state ISSUE.
//      imm_mask==0: no micro-ops. done pulses in the next cycle. State stays IDLE.
//  - IDLE, any other opcode or start=0: no action. stall=0.
//  - stall (combinational) = (state==ISSUE) | (state==IDLE & start & is_lmsm & imm_mask!=0).
//  - ISSUE: uop_valid=1.
//      uop_reg = index of the highest set bit of mask_q (bit7->0 ... bit0->7).
//      uop_addr = addr_q. uop_last = (popcount(mask_q)==1).
//  - Handshake: outputs hold stable while uop_valid & !uop_ready.
//      On uop_valid & uop_ready: clear mask_q bit (7-uop_reg); addr_q <= addr_q+1.
//      addr_q is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
//      If uop_last: state -> IDLE and done pulses in the next cycle.
//  - Latency: start at cycle N -> first uop_valid at N+1. k set bits with uop_ready tied high ->
//    micro-ops at N+1..N+k, done at N+k+1.
//  - start while in ISSUE is ignored; decode is stalled, so it re-presents the instruction.
//  - flush (any state): state -> IDLE, mask_q=0, no done, remaining micro-ops discarded.
//    flush has priority over start and over the handshake in the same cycle.
//  - rst mid-sequence: same as reset; no done pulse.
//  - uop_is_load = is_load_q, valid only when uop_valid=1.
//    uop_reg, uop_addr and uop_last drive 0 when uop_valid=0.
// STRUCTURE
//  - Shared package (risc_pkg): OPC_LM=4'b1100, OPC_SM=4'b1101, ADDR_W, REG_W.
//    FSM state enum lmsm_state_t {IDLE, ISSUE}.
//  - One sub-module, lmsm_prio_enc: combinational MSB-first encoder, mask[7:0] -> {any, idx[2:0], single}.
//    single = exactly one bit set.
//  - Top holds the FSM, the mask/address registers and the output muxing.
// TESTING
//  - LM, mask=8'b1010_0001, base=16'h0040, ready=1:
//      -> uops (reg0,0040), (reg2,0041), (reg7,0042); uop_last only on the third; done at N+4.
//  - SM, mask=8'hFF, base=16'hFFFE, ready toggles 1/0:
//      -> 8 uops reg0..7, addr FFFE, FFFF, 0000, ... 0005.
//      -> outputs hold while ready=0; uop_is_load=0 throughout.
//  - LM with mask=8'h00:
//      -> no uop_valid; stall never asserted; done pulses at N+1.
//  - LM with mask=8'h18; flush asserted during the first uop with ready=1:
//      -> IDLE next cycle, no second uop, no done.
//      rst mid-sequence behaves identically.
//  - Non-LM/SM opcode with start=1, and start re-asserted during ISSUE:
//      -> no state change, no stall; the in-flight sequence is unaffected.
//  - Random masks with random uop_ready:
//      -> popcount(mask) uops in MSB-first order; addresses consecutive from base; exactly one done.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared opcodes, widths and the LM/SM sequencer state type.
package risc_pkg;

  localparam int ADDR_W = 16;
  localparam int MASK_W = 8;
  localparam int REG_W  = 3;

  localparam logic [3:0] OPC_LM = 4'b1100;
  localparam logic [3:0] OPC_SM = 4'b1101;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } lmsm_state_t;

  // True for either multi-register memory opcode
  function automatic logic is_lmsm(input logic [3:0] opc);
    return (opc == OPC_LM) || (opc == OPC_SM);
  endfunction

endpackage

// File: rtl/lmsm_prio_enc.sv
// MSB-first priority encoder: mask bit 7 maps to register 0, bit 0 to register 7.
module lmsm_prio_enc
  import risc_pkg::*;
#(
  parameter int MASK_W = risc_pkg::MASK_W,
  parameter int REG_W  = risc_pkg::REG_W
) (
  input  logic [MASK_W-1:0] mask,
  output logic              any,
  output logic [REG_W-1:0]  idx,
  output logic              single
);

  // Scan upward so the highest set bit is the last to write idx
  always_comb begin
    idx = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) idx = REG_W'(MASK_W - 1 - i);
    end
  end

  assign any    = |mask;
  assign single = any && ((mask & (mask - MASK_W'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: expands one load/store-multiple into per-register micro-ops
// issued R0 first, stalling fetch/decode until the final micro-op is accepted.
module lmsm_sequencer
  import risc_pkg::*;
#(
  parameter int ADDR_W = risc_pkg::ADDR_W,
  parameter int MASK_W = risc_pkg::MASK_W,
  parameter int REG_W  = risc_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [MASK_W-1:0] imm_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              uop_ready,
  output logic              uop_valid,
  output logic              uop_is_load,
  output logic [REG_W-1:0]  uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              stall,
  output logic              done
);

  lmsm_state_t       r_state;
  logic [MASK_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_load;
  logic              r_done;

  logic              w_any;
  logic [REG_W-1:0]  w_idx;
  logic              w_single;
  logic              w_accept;
  logic              w_launch;
  logic              w_empty_op;
  logic [MASK_W-1:0] w_clr;

  lmsm_prio_enc #(
    .MASK_W (MASK_W),
    .REG_W  (REG_W)
  ) u_enc (
    .mask   (r_mask),
    .any    (w_any),
    .idx    (w_idx),
    .single (w_single)
  );

  assign w_accept   = (r_state == ISSUE) && uop_ready;
  assign w_launch   = (r_state == IDLE) && start && is_lmsm(opcode) && (imm_mask != '0);
  assign w_empty_op = (r_state == IDLE) && start && is_lmsm(opcode) && (imm_mask == '0);
  // One-hot of the mask bit belonging to the register being issued
  assign w_clr      = MASK_W'(1) << (REG_W'(MASK_W - 1) - w_idx);

  // FSM with mask/address bookkeeping; flush overrides start and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_addr    <= '0;
      r_is_load <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_mask  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_launch) begin
              r_mask    <= imm_mask;
              r_addr    <= base_addr;
              r_is_load <= (opcode == OPC_LM);
              r_state   <= ISSUE;
            end else if (w_empty_op) begin
              r_done <= 1'b1;
            end
          end
          ISSUE: begin
            if (w_accept) begin
              r_mask <= r_mask & ~w_clr;
              r_addr <= r_addr + ADDR_W'(1);
              if (w_single || !w_any) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Output muxing: micro-op fields are zeroed whenever no micro-op is present
  always_comb begin
    uop_valid   = (r_state == ISSUE);
    uop_is_load = uop_valid ? r_is_load : 1'b0;
    uop_reg     = uop_valid ? w_idx     : '0;
    uop_addr    = uop_valid ? r_addr    : '0;
    uop_last    = uop_valid ? w_single  : 1'b0;
    stall       = (r_state == ISSUE) || w_launch;
    done        = r_done;
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed and randomised checks of the LM/SM sequencer.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush, uop_ready;
  logic [3:0]  opcode;
  logic [7:0]  imm_mask;
  logic [15:0] base_addr;
  logic        uop_valid, uop_is_load, uop_last, stall, done;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;

  int errors = 0;
  int checks = 0;

  lmsm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .imm_mask(imm_mask),
    .base_addr(base_addr), .flush(flush), .uop_ready(uop_ready),
    .uop_valid(uop_valid), .uop_is_load(uop_is_load), .uop_reg(uop_reg),
    .uop_addr(uop_addr), .uop_last(uop_last), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; uop_ready = 1'b0;
    opcode = 4'h0; imm_mask = 8'h00; base_addr = 16'h0000;
    step(); step();
    checks++; if ({uop_valid, uop_is_load, uop_last, stall, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {uop_valid, uop_is_load, uop_last, stall, done}); end
    checks++; if ({uop_reg, uop_addr} !== 19'h0) begin
      errors++; $display("FAIL reset_fields got reg=%0d addr=%h exp 0/0000", uop_reg, uop_addr); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lm_basic();
    logic [2:0]  exp_reg [3];
    logic [15:0] exp_addr [3];
    exp_reg = '{3'd0, 3'd2, 3'd7};
    exp_addr = '{16'h0040, 16'h0041, 16'h0042};
    start = 1'b1; opcode = 4'b1100; imm_mask = 8'b1010_0001; base_addr = 16'h0040; uop_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b1 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL lm_launch stall=%b valid=%b exp stall=1 valid=0", stall, uop_valid); end
    step();
    start = 1'b0; imm_mask = 8'h00; base_addr = 16'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({uop_valid, uop_is_load, stall, done} !== 4'b1110) begin
        errors++; $display("FAIL lm_ctrl%0d got=%b exp=1110", i, {uop_valid, uop_is_load, stall, done}); end
      checks++; if (uop_reg !== exp_reg[i] || uop_addr !== exp_addr[i]) begin
        errors++; $display("FAIL lm_uop%0d got reg=%0d addr=%h exp reg=%0d addr=%h", i, uop_reg, uop_addr, exp_reg[i], exp_addr[i]); end
      checks++; if (uop_last !== (i == 2)) begin
        errors++; $display("FAIL lm_last%0d got=%b exp=%b", i, uop_last, (i == 2)); end
      step();
    end
    checks++; if (done !== 1'b1 || uop_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL lm_done got done=%b valid=%b stall=%b exp 1/0/0", done, uop_valid, stall); end
    step();
    checks++; if (done !== 1'b0) begin
      errors++; $display("FAIL lm_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_sm_wrap();
    logic [15:0] ea;
    start = 1'b1; opcode = 4'b1101; imm_mask = 8'hFF; base_addr = 16'hFFFE; uop_ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ea = 16'hFFFE + 16'(i);
      for (int ph = 0; ph < 2; ph++) begin
        uop_ready = (ph == 1);
        #1;
        checks++; if (uop_valid !== 1'b1 || uop_is_load !== 1'b0 || uop_reg !== 3'(i) || uop_addr !== ea) begin
          errors++; $display("FAIL sm_uop%0d_ph%0d got v=%b ld=%b reg=%0d addr=%h exp v=1 ld=0 reg=%0d addr=%h",
                             i, ph, uop_valid, uop_is_load, uop_reg, uop_addr, i, ea); end
        checks++; if (uop_last !== (i == 7) || done !== 1'b0) begin
          errors++; $display("FAIL sm_last%0d_ph%0d got last=%b done=%b exp last=%b done=0", i, ph, uop_last, done, (i == 7)); end
        step();
      end
    end
    checks++; if (done !== 1'b1 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL sm_done got done=%b valid=%b exp 1/0", done, uop_valid); end
    uop_ready = 1'b0;
    step();
  endtask

  task automatic test_zero_mask();
    start = 1'b1; opcode = 4'b1100; imm_mask = 8'h00; base_addr = 16'h1234; uop_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL zero_stall got=%b exp=0", stall); end
    step();
    start = 1'b0;
    checks++; if (done !== 1'b1 || uop_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b valid=%b stall=%b exp 1/0/0", done, uop_valid, stall); end
    step();
    checks++; if (done !== 1'b0 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after got done=%b valid=%b exp 0/0", done, uop_valid); end
  endtask

  // mode 0 aborts with flush, mode 1 aborts with rst
  task automatic test_abort(input int mode);
    start = 1'b1; opcode = 4'b1100; imm_mask = 8'h18; base_addr = 16'h0100; uop_ready = 1'b1;
    step();
    start = 1'b0;
    checks++; if (uop_valid !== 1'b1 || uop_reg !== 3'd3 || uop_addr !== 16'h0100) begin
      errors++; $display("FAIL abort%0d_first got v=%b reg=%0d addr=%h exp 1/3/0100", mode, uop_valid, uop_reg, uop_addr); end
    if (mode == 0) flush = 1'b1; else rst = 1'b1;
    step();
    flush = 1'b0; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (uop_valid !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
        errors++; $display("FAIL abort%0d_c%0d got v=%b done=%b stall=%b exp 0/0/0", mode, c, uop_valid, done, stall); end
      step();
    end
  endtask

  task automatic test_ignore();
    start = 1'b1; opcode = 4'b0000; imm_mask = 8'hFF; base_addr = 16'h0500; uop_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL ign_opc_stall got=%b exp=0", stall); end
    step();
    checks++; if (uop_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ign_opc got v=%b done=%b exp 0/0", uop_valid, done); end
    opcode = 4'b1100; imm_mask = 8'hC0; base_addr = 16'h0020; uop_ready = 1'b0;
    step();
    opcode = 4'b1101; imm_mask = 8'h01; base_addr = 16'h0999;
    step();
    checks++; if (uop_valid !== 1'b1 || uop_is_load !== 1'b1 || uop_reg !== 3'd0 || uop_addr !== 16'h0020 || uop_last !== 1'b0) begin
      errors++; $display("FAIL ign_hold got v=%b ld=%b reg=%0d addr=%h last=%b exp 1/1/0/0020/0",
                         uop_valid, uop_is_load, uop_reg, uop_addr, uop_last); end
    uop_ready = 1'b1;
    step();
    start = 1'b0;
    checks++; if (uop_valid !== 1'b1 || uop_is_load !== 1'b1 || uop_reg !== 3'd1 || uop_addr !== 16'h0021 || uop_last !== 1'b1) begin
      errors++; $display("FAIL ign_second got v=%b ld=%b reg=%0d addr=%h last=%b exp 1/1/1/0021/1",
                         uop_valid, uop_is_load, uop_reg, uop_addr, uop_last); end
    step();
    checks++; if (done !== 1'b1 || uop_valid !== 1'b0) begin
      errors++; $display("FAIL ign_done got done=%b v=%b exp 1/0", done, uop_valid); end
    step();
  endtask

  task automatic test_random();
    logic [7:0]  m, mask;
    logic [15:0] a;
    logic [2:0]  er;
    int          cnt, pc;
    bit          seen;
    for (int t = 0; t < 6; t++) begin
      mask = 8'($urandom_range(1, 255));
      a = 16'($urandom);
      m = mask; cnt = 0; seen = 1'b0; pc = $countones(mask);
      start = 1'b1; opcode = ($urandom_range(0, 1) != 0) ? 4'b1100 : 4'b1101;
      imm_mask = mask; base_addr = a; uop_ready = 1'b0;
      step();
      start = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
        if (done) begin seen = 1'b1; break; end
        uop_ready = $urandom_range(0, 1) != 0;
        #1;
        checks++; if (uop_valid !== (m != 0)) begin
          errors++; $display("FAIL rnd%0d_valid got=%b exp=%b", t, uop_valid, (m != 0)); end
        if (uop_valid && uop_ready) begin
          er = 3'd0;
          for (int b = 0; b < 8; b++) if (m[b]) er = 3'(7 - b);
          checks++; if (uop_reg !== er || uop_addr !== a || uop_last !== ($countones(m) == 1)) begin
            errors++; $display("FAIL rnd%0d_uop%0d got reg=%0d addr=%h last=%b exp reg=%0d addr=%h last=%b",
                               t, cnt, uop_reg, uop_addr, uop_last, er, a, ($countones(m) == 1)); end
          m[3'(7) - er] = 1'b0;
          a = a + 16'd1;
          cnt++;
        end
        step();
      end
      checks++; if (!seen || cnt != pc) begin
        errors++; $display("FAIL rnd%0d_count got uops=%0d done=%b exp uops=%0d done=1", t, cnt, seen, pc); end
      uop_ready = 1'b0;
      step();
      checks++; if (done !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_single_done got=%b exp=0", t, done); end
    end
  endtask

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_zero_mask();
    test_abort(0);
    test_abort(1);
    test_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
